accum_sequencer: RTL

- Fetch/decode/execute control unit for the 16-bit accumulator machine.
- Owns PC, IR, MAR, MBR and ACC internally.
- Drives the main-memory port and the combinational ALU, whose result it consumes.
- Sits directly upstream of main memory and the ALU.
- Sequences one instruction at a time from a multi-cycle state machine.

---
 rtl/accum_seq_pkg.sv | 49 ++++
 rtl/accum_seq_decode.sv | 33 +++
 rtl/accum_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/accum_seq_pkg.sv
// Shared opcodes, FSM states, instruction classes and ALU codes for the accumulator sequencer.
package accum_seq_pkg;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUBT     = 4'h4;
  localparam logic [3:0] OP_AND      = 4'h5;
  localparam logic [3:0] OP_OR       = 4'h6;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;
  localparam logic [3:0] OP_CLEAR    = 4'hA;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  localparam logic [1:0] SC_NEG   = 2'b00;
  localparam logic [1:0] SC_ZERO  = 2'b01;
  localparam logic [1:0] SC_POS   = 2'b10;
  localparam logic [1:0] SC_NEVER = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_FWAIT  = 4'd2,
    S_DECODE = 4'd3,
    S_MRD    = 4'd4,
    S_MWAIT  = 4'd5,
    S_EXEC   = 4'd6,
    S_STORE  = 4'd7,
    S_HALT   = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP   = 3'd0,
    CL_LOAD  = 3'd1,
    CL_ALU   = 3'd2,
    CL_STORE = 3'd3,
    CL_CLEAR = 3'd4,
    CL_JUMP  = 3'd5,
    CL_SKIP  = 3'd6,
    CL_HALT  = 3'd7
  } iclass_e;

endpackage

// File: rtl/accum_seq_decode.sv
// Combinational opcode decoder: instruction class, operand-read need, ALU op and legality.
module accum_seq_decode
  import accum_seq_pkg::*;
(
  input  logic [3:0] opcode_i,
  output iclass_e    iclass_o,
  output logic       needs_mem_read_o,
  output logic [3:0] alu_op_o,
  output logic       legal_o
);

  always_comb begin
    iclass_o         = CL_NOP;
    needs_mem_read_o = 1'b0;
    alu_op_o         = ALU_ADD;
    legal_o          = 1'b1;
    case (opcode_i)
      OP_NOP:      iclass_o = CL_NOP;
      OP_LOAD:     begin iclass_o = CL_LOAD; needs_mem_read_o = 1'b1; end
      OP_STORE:    iclass_o = CL_STORE;
      OP_ADD:      begin iclass_o = CL_ALU; needs_mem_read_o = 1'b1; alu_op_o = ALU_ADD; end
      OP_SUBT:     begin iclass_o = CL_ALU; needs_mem_read_o = 1'b1; alu_op_o = ALU_SUB; end
      OP_AND:      begin iclass_o = CL_ALU; needs_mem_read_o = 1'b1; alu_op_o = ALU_AND; end
      OP_OR:       begin iclass_o = CL_ALU; needs_mem_read_o = 1'b1; alu_op_o = ALU_OR;  end
      OP_HALT:     iclass_o = CL_HALT;
      OP_SKIPCOND: iclass_o = CL_SKIP;
      OP_JUMP:     iclass_o = CL_JUMP;
      OP_CLEAR:    iclass_o = CL_CLEAR;
      default:     legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/accum_sequencer.sv
// Fetch/decode/execute sequencer for the 16-bit accumulator machine.
// ACCSEQ_ILLEGAL_TRAP_EN: opcodes 0xB-0xF trap to HALT and set illegal; otherwise they run as NOP.
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        alu_op,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       acc_out,
  output logic [15:0]       ir_out
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d, pc_inc;
  logic [15:0]       ir_q, ir_d, mbr_q, mbr_d, acc_q, acc_d;
  logic              skip;

  iclass_e    dec_class;
  logic       dec_mem_rd, dec_legal;
  logic [3:0] dec_alu_op;

`ifdef ACCSEQ_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  accum_seq_decode u_decode (
    .opcode_i        (ir_q[15:12]),
    .iclass_o        (dec_class),
    .needs_mem_read_o(dec_mem_rd),
    .alu_op_o        (dec_alu_op),
    .legal_o         (dec_legal)
  );

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign mem_wdata = acc_q;
  assign alu_a     = acc_q;
  assign alu_b     = mbr_q;
  assign halted    = (state_q == S_HALT);
  assign pc_out    = pc_q;
  assign acc_out   = acc_q;
  assign ir_out    = ir_q;

  always_comb begin
    case (ir_q[11:10])
      SC_NEG:  skip = acc_q[15];
      SC_ZERO: skip = (acc_q == '0);
      SC_POS:  skip = !acc_q[15] && (acc_q != '0);
      default: skip = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    mar_d    = mar_q;
    mbr_d    = mbr_q;
    acc_d    = acc_q;
    mem_addr = mar_q;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    alu_op   = ALU_ADD;
`ifdef ACCSEQ_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          state_d = S_FETCH;
`ifdef ACCSEQ_ILLEGAL_TRAP_EN
          illegal_d = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        mem_addr = pc_q;
        mem_re   = 1'b1;
        mar_d    = pc_q;
        state_d  = S_FWAIT;
      end
      S_FWAIT: begin
        ir_d    = mem_rdata;
        pc_d    = pc_inc;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        if (!dec_legal) begin
`ifdef ACCSEQ_ILLEGAL_TRAP_EN
          state_d   = S_HALT;
          illegal_d = 1'b1;
`else
          state_d   = S_FETCH;
`endif
        end else if (dec_mem_rd) begin
          mar_d   = ir_q[ADDR_W-1:0];
          state_d = S_MRD;
        end else begin
          case (dec_class)
            CL_STORE: begin mar_d = ir_q[ADDR_W-1:0]; state_d = S_STORE; end
            CL_CLEAR: acc_d = '0;
            CL_JUMP:  pc_d  = ir_q[ADDR_W-1:0];
            CL_SKIP:  if (skip) pc_d = pc_inc;
            CL_HALT:  state_d = S_HALT;
            default:  state_d = S_FETCH;
          endcase
        end
      end
      S_MRD: begin
        mem_re  = 1'b1;
        state_d = S_MWAIT;
      end
      S_MWAIT: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_op  = dec_alu_op;
        acc_d   = (dec_class == CL_LOAD) ? mbr_q : alu_result;
        state_d = S_FETCH;
      end
      S_STORE: begin
        mem_we  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      acc_q   <= '0;
`ifdef ACCSEQ_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      acc_q   <= acc_d;
`ifdef ACCSEQ_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

endmodule
